// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO input capture controller: default load addresses,
// status-word bit positions and the read-mux selector.
package mmio_pkg;

    localparam logic [7:0] DEF_DATA_ADDR = 8'hFF;
    localparam logic [7:0] DEF_STAT_ADDR = 8'hFE;

    localparam int unsigned ST_OVF     = 7;
    localparam int unsigned ST_FULL    = 6;
    localparam int unsigned ST_EMPTY   = 5;
    localparam int unsigned ST_CNT_MSB = 3;

    typedef enum logic [1:0] {
        SEL_MEM,
        SEL_DATA,
        SEL_STAT
    } rd_sel_e;

endpackage

// File: rtl/mmio_in_ctrl_if.sv
// CPU load bus seen by the capture controller: address, load strobe,
// memory read data in, and the load result back to the register file.
interface mmio_in_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] Address;
    logic             Rd_en;
    logic [WIDTH-1:0] MemData;
    logic [WIDTH-1:0] RegData;

    modport master (output Address, output Rd_en, output MemData, input RegData);
    modport slave  (input Address, input Rd_en, input MemData, output RegData);
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser plus one edge-history flop; flags a rising edge of an
// asynchronous input for exactly one clock.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise_pulse = s2 & ~s3;

endmodule

// File: rtl/mmio_in_ctrl.sv
// Captures strobed external data into a small FIFO and exposes it to CPU loads
// through a memory-mapped data port and status word; Irq flags a non-empty FIFO.
module mmio_in_ctrl
    import mmio_pkg::*;
#(
    parameter int unsigned    WIDTH     = 8,
    parameter int unsigned    DEPTH     = 4,
    parameter logic [WIDTH-1:0] DATA_ADDR = WIDTH'(DEF_DATA_ADDR),
    parameter logic [WIDTH-1:0] STAT_ADDR = WIDTH'(DEF_STAT_ADDR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             In_strobe,
    mmio_in_ctrl_if.slave    bus,
    output logic             Irq
);

    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned CNT_FLD_W = ST_CNT_MSB + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             ovf;

    logic             rise;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push_ok;
    logic             ovf_evt;
    logic             ovf_clr;
    rd_sel_e          sel;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] status;

    sync_edge u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (In_strobe),
        .rise_pulse (rise)
    );

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop     = bus.Rd_en && (bus.Address == DATA_ADDR) && !empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign push_ok = rise && (!full || pop);
    assign ovf_evt = rise && full && !pop;
    assign ovf_clr = bus.Rd_en && (bus.Address == STAT_ADDR);

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop)      count_nxt = count + CNT_W'(1);
        else if (pop && !push_ok) count_nxt = count - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            Irq    <= 1'b0;
        end else begin
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            count <= count_nxt;
            // Overflow set takes priority over a coincident status-read clear.
            if (ovf_evt)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
            Irq <= (count_nxt != '0);
        end
    end

    // Storage carries no reset; empty reads are masked at the mux instead.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= Data_in;
    end

    assign head = empty ? '0 : mem[rd_ptr];

    always_comb begin
        status                  = '0;
        status[ST_OVF]          = ovf;
        status[ST_FULL]         = full;
        status[ST_EMPTY]        = empty;
        status[ST_CNT_MSB:0]    = CNT_FLD_W'(count);
    end

    always_comb begin
        sel = SEL_MEM;
        if (bus.Address == DATA_ADDR)      sel = SEL_DATA;
        else if (bus.Address == STAT_ADDR) sel = SEL_STAT;
    end

    always_comb begin
        bus.RegData = bus.MemData;
        case (sel)
            SEL_DATA: bus.RegData = head;
            SEL_STAT: bus.RegData = status;
            default:  bus.RegData = bus.MemData;
        endcase
    end

endmodule

// File: tb/tb_mmio_in_ctrl.sv
// Self-checking bench for mmio_in_ctrl: directed scenarios followed by random
// strobes and CPU loads, checked against a queue-based reference model.
module tb_mmio_in_ctrl;

    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       in_strobe;
    logic [7:0] addr;
    logic       rd_en;
    logic [7:0] mem_data;
    logic       irq;

    mmio_in_ctrl_if #(.WIDTH(8)) bus_if ();

    assign bus_if.Address = addr;
    assign bus_if.Rd_en   = rd_en;
    assign bus_if.MemData = mem_data;

    mmio_in_ctrl #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Data_in   (data_in),
        .In_strobe (in_strobe),
        .bus       (bus_if),
        .Irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: FIFO contents, sticky overflow, edges left until a pending push.
    logic [7:0] q [$];
    bit         m_ovf;
    int         pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_status();
        int sz;
        sz = q.size();
        return {m_ovf, (sz == DEPTH), (sz == 0), 1'b0, 4'(sz)};
    endfunction

    function automatic logic [7:0] exp_regdata();
        if (addr == 8'hFF) return (q.size() != 0) ? q[0] : 8'h00;
        if (addr == 8'hFE) return exp_status();
        return mem_data;
    endfunction

    task automatic model_edge();
        bit pop_e;
        bit push_e;
        bit clr;
        bit evt;
        if (!rst_n) return;
        pop_e  = rd_en && (addr == 8'hFF) && (q.size() != 0);
        push_e = 1'b0;
        if (pend > 0) begin
            pend--;
            push_e = (pend == 0);
        end
        clr = rd_en && (addr == 8'hFE);
        evt = push_e && (q.size() == DEPTH) && !pop_e;
        if (pop_e) void'(q.pop_front());
        if (push_e && !evt) q.push_back(data_in);
        if (clr) m_ovf = 1'b0;
        if (evt) m_ovf = 1'b1;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        pend  = 0;
    endtask

    task automatic raise(input logic [7:0] d);
        data_in   = d;
        in_strobe = 1'b1;
        pend      = 3;
    endtask

    // One bus cycle: drive at negedge, check away from the edge, advance one clock.
    task automatic cyc(input logic [7:0] a, input logic rd, input logic [7:0] md);
        addr     = a;
        rd_en    = rd;
        mem_data = md;
        #1;
        chk("regdata", 32'(bus_if.RegData), 32'(exp_regdata()));
        chk("irq", 32'(irq), 32'(q.size() != 0));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] d);
        raise(d);
        repeat (4) cyc(8'hFE, 1'b0, 8'h00);
        in_strobe = 1'b0;
        repeat (3) cyc(8'hFE, 1'b0, 8'h00);
    endtask

    initial begin
        int hi_left;
        int lo_left;
        int r;
        logic [7:0] a;
        rst_n = 1'b0; data_in = '0; in_strobe = 1'b0;
        addr = '0; rd_en = 1'b0; mem_data = '0;
        m_ovf = 1'b0; pend = 0;
        repeat (2) @(negedge clk);

        // Reset state and memory pass-through
        cyc(8'hFE, 1'b0, 8'h00);
        chk("reset_status", 32'(bus_if.RegData), 32'h20);
        rst_n = 1'b1;
        cyc(8'h10, 1'b0, 8'h55);

        // Single capture with exact three-edge latency
        raise(8'hAA);
        repeat (3) cyc(8'hFE, 1'b0, 8'h00);
        in_strobe = 1'b0;
        repeat (2) cyc(8'hFE, 1'b0, 8'h00);
        cyc(8'hFF, 1'b1, 8'h00);
        cyc(8'hFE, 1'b0, 8'h00);

        // Overfill, sticky overflow, clear-on-read, drain in order
        pulse(8'h11); pulse(8'h22); pulse(8'h33); pulse(8'h44); pulse(8'h55);
        cyc(8'hFE, 1'b0, 8'h00);
        cyc(8'hFE, 1'b1, 8'h00);
        cyc(8'hFE, 1'b0, 8'h00);
        repeat (5) cyc(8'hFF, 1'b1, 8'h00);

        // Long strobe pushes once
        raise(8'h66);
        repeat (20) cyc(8'hFE, 1'b0, 8'h00);
        in_strobe = 1'b0;
        repeat (3) cyc(8'hFE, 1'b0, 8'h00);
        cyc(8'hFF, 1'b1, 8'h00);

        // Overflow coincident with status-read clear keeps overflow set
        pulse(8'hA1); pulse(8'hA2); pulse(8'hA3); pulse(8'hA4);
        raise(8'h77);
        repeat (2) cyc(8'hFE, 1'b0, 8'h00);
        cyc(8'hFE, 1'b1, 8'h00);
        in_strobe = 1'b0;
        cyc(8'hFE, 1'b0, 8'h00);
        cyc(8'hFE, 1'b1, 8'h00);
        cyc(8'hFE, 1'b0, 8'h00);

        // Full FIFO: pop coincident with push of 8'h99
        raise(8'h99);
        repeat (2) cyc(8'hFE, 1'b0, 8'h00);
        cyc(8'hFF, 1'b1, 8'h00);
        in_strobe = 1'b0;
        repeat (2) cyc(8'hFE, 1'b0, 8'h00);
        repeat (5) cyc(8'hFF, 1'b1, 8'h00);

        // Reset mid-capture discards the in-flight edge
        pulse(8'h3C);
        raise(8'h5A);
        cyc(8'hFE, 1'b0, 8'h00);
        assert_reset();
        cyc(8'hFE, 1'b0, 8'h00);
        in_strobe = 1'b0;
        cyc(8'hFE, 1'b0, 8'h00);
        rst_n = 1'b1;
        repeat (5) cyc(8'hFE, 1'b0, 8'h00);

        // Random strobes and loads; read-heavy and read-light phases alternate
        hi_left = 0;
        lo_left = 3;
        for (int i = 0; i < 3000; i++) begin
            if (in_strobe) begin
                if (hi_left == 0) begin
                    in_strobe = 1'b0;
                    lo_left   = $urandom_range(2, 8);
                end else begin
                    hi_left--;
                end
            end else if (lo_left > 0) begin
                lo_left--;
            end else if ($urandom_range(0, 2) == 0) begin
                raise(8'($urandom));
                hi_left = $urandom_range(2, 8);
            end
            r = $urandom_range(0, 9);
            if (((i / 300) % 2) == 1 && r < 4) a = 8'hFF;
            else if (r == 4 || r == 5)          a = 8'hFE;
            else if (r == 6)                    a = 8'hFF;
            else                                a = 8'($urandom_range(0, 253));
            cyc(a, 1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mmio_in_ctrl.md
MMIO_IN_CTRL -- requirements
Module: mmio_in_ctrl

Interface
- REQ-001 Parameter WIDTH, default 8: data and address width; WIDTH SHALL be >= 8.
- REQ-002 Parameter DEPTH, default 4: capture FIFO depth; DEPTH SHALL be a power of two, 2..8.
- REQ-003 Parameter DATA_ADDR, default 8'hFF: read address that returns and pops the FIFO head.
- REQ-004 Parameter STAT_ADDR, default 8'hFE: read address that returns the status word.
- REQ-005 clk  input  1  single clock; all state updates on the rising edge.
- REQ-006 rst_n  input  1  reset, asynchronous, active-low.
- REQ-007 Data_in  input  WIDTH  external parallel data, held stable from before In_strobe rises until it falls.
- REQ-008 In_strobe  input  1  external capture strobe, asynchronous to clk.
- REQ-009 Address  input  WIDTH  CPU load address.
- REQ-010 Rd_en  input  1  CPU load strobe, one cycle per load instruction.
- REQ-011 MemData  input  WIDTH  data memory read data.
- REQ-012 RegData  output  WIDTH  load result to register file.
- REQ-013 Irq  output  1  high while FIFO non-empty.

Function
- REQ-014 In_strobe SHALL pass through a two-flop synchroniser plus a third edge-history flop; a rising edge is detected when stage2=1 and stage3=0.
- REQ-015 On a detected edge, Data_in SHALL be written to the FIFO at the third rising clk edge after In_strobe rises; count increments at that edge.
- REQ-016 One push per strobe pulse; a strobe held high SHALL NOT push again.
- REQ-017 RegData SHALL be combinational: FIFO head when Address==DATA_ADDR, status word when Address==STAT_ADDR, MemData otherwise; Rd_en does not gate the mux.
- REQ-018 Status word: bit7 overflow, bit6 full, bit5 empty, bits[3:0] count, other bits 0.
- REQ-019 Rd_en=1 with Address==DATA_ADDR and FIFO non-empty SHALL pop the head at the next rising edge.
- REQ-020 Read of DATA_ADDR when empty SHALL return 0 and change no state.
- REQ-021 Push when full (no simultaneous pop) SHALL be dropped and set sticky overflow.
- REQ-022 Simultaneous push and pop when full: pop then push; count stays DEPTH; overflow unchanged.
- REQ-023 Simultaneous push and pop when empty: pop ignored, read returns 0, push completes, count becomes 1.
- REQ-024 Rd_en=1 with Address==STAT_ADDR SHALL clear overflow at the next edge; if an overflow event occurs in the same cycle, set wins.
- REQ-025 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits, range 0..DEPTH.
- REQ-026 Irq SHALL equal (count != 0), registered state only.

Reset
- REQ-027 rst_n low SHALL immediately clear synchroniser flops, pointers, count and overflow; Irq=0; status reads 8'h20.
- REQ-028 Reset asserted mid-capture SHALL discard the in-flight edge; no push occurs after release until a new rising strobe is synchronised.
- REQ-029 FIFO storage SHALL NOT require reset; empty head reads return 0 regardless of storage content.

Structure
- REQ-030 Package mmio_pkg SHALL hold DATA_ADDR/STAT_ADDR defaults and status bit-position constants (ST_OVF=7, ST_FULL=6, ST_EMPTY=5, ST_CNT_MSB=3).
- REQ-031 Sub-module sync_edge SHALL implement the synchroniser plus rising-edge detect (inputs clk, rst_n, async_in; output rise_pulse).
- REQ-032 FIFO storage, pointers, count, status and read mux SHALL be in mmio_in_ctrl.

Verification
- REQ-033 Reset then Address=8'hFE -> RegData=8'h20, Irq=0; Address=8'h10, MemData=8'h55 -> RegData=8'h55.
- REQ-034 Data_in=8'hAA, one strobe pulse -> count=1 exactly three edges after strobe rise, Irq=1; load from 8'hFF -> RegData=8'hAA, then status 8'h20.
- REQ-035 Push 8'h11,22,33,44,55 with no reads -> status 8'hC4; four reads return 11,22,33,44 in order (pointer wrap exercised on refill); 55 never appears.
- REQ-036 After overflow, read 8'hFE -> bit7=1 on that read, bit7=0 on the next; a coincident overflow keeps bit7=1.
- REQ-037 FIFO full and pop coincident with a push of 8'h99 -> count stays 4, overflow stays 0, 8'h99 is the last word read.
- REQ-038 Strobe held high for 20 cycles -> exactly one push; rst_n pulsed one cycle after strobe rise -> count stays 0.
